// File: rtl/lbp_pkg.sv
// Shared types, neighbour bit positions and the optional uniform-label function for the LBP engine.
// Optional build macro LBP_UNIFORM_EN adds the rotation-invariant uniform label helper.
package lbp_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_BL = 5;
  localparam int NB_B  = 6;
  localparam int NB_BR = 7;

`ifdef LBP_UNIFORM_EN
  // Walk the neighbours clockwise so transitions are counted around the true ring.
  function automatic logic [7:0] uniform_label(input logic [7:0] code);
    logic [7:0] ring;
    logic [3:0] trans;
    logic [3:0] ones;
    ring  = {code[NB_L], code[NB_BL], code[NB_B], code[NB_BR],
             code[NB_R], code[NB_TR], code[NB_T], code[NB_TL]};
    trans = '0;
    ones  = '0;
    for (int i = 0; i < 8; i++) begin
      trans = trans + 4'(ring[i] != ring[(i + 1) % 8]);
      ones  = ones + 4'(ring[i]);
    end
    return (trans <= 4'd2) ? {4'd0, ones} : 8'd9;
  endfunction
`endif

endpackage

// File: rtl/lbp_stream_engine_if.sv
// Pixel-read and code-write bus of the LBP engine; master is the engine, slave the memory side.
// No back-pressure on the write side; reads stall on gray_ready.
interface lbp_stream_engine_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_req;
  logic              gray_ready;
  logic [PIX_W-1:0]  gray_data;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic [7:0]        lbp_data;
  logic              finish;

  modport master (
    output gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish,
    input  gray_ready, gray_data
  );

  modport slave (
    input  gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish,
    output gray_ready, gray_data
  );
endinterface

// File: rtl/lbp_line_buffer.sv
// One image row of delay: o_dout is the sample written DEPTH enabled cycles ago (circular RAM).
// Advances only when i_en is high; no internal back-pressure.
module lbp_line_buffer #(
  parameter int DEPTH = 128,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_dout
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  // Read-before-write at the same slot gives exactly DEPTH samples of delay.
  assign o_dout = r_mem[r_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end
endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: code for centre k-IMG_W-1 is written the cycle after pixel k is read.
// Reads stall on gray_ready; writes are never stalled. LBP_UNIFORM_EN selects uniform labels.
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                clk,
  input  logic                reset_n,
  lbp_stream_engine_if.master bus
);
  localparam int CX_W = $clog2(IMG_W);
  localparam int CY_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] FIRST_EMIT = ADDR_W'(IMG_W + 1);

  state_t            r_state, w_state_nxt;
  logic              w_accept, w_emit, w_border;
  logic [7:0]        w_code, w_out;
  logic [PIX_W-1:0]  w_lb1, w_lb2;
  logic [PIX_W-1:0]  r_win [3][3];
  logic [ADDR_W-1:0] r_gaddr, r_caddr, r_laddr;
  logic              r_req, r_valid, r_finish;
  logic [7:0]        r_data;
  logic [CX_W-1:0]   r_cx;
  logic [CY_W-1:0]   r_cy;

  lbp_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_din(bus.gray_data), .o_dout(w_lb1)
  );
  lbp_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb2 (
    .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_din(w_lb1), .o_dout(w_lb2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.gray_ready) w_state_nxt = READ;
      READ:    if (w_accept && r_gaddr == LAST) w_state_nxt = DRAIN;
      DRAIN:   if (r_caddr == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == READ) && r_req && bus.gray_ready;
    w_emit   = (w_accept && r_gaddr >= FIRST_EMIT) || (r_state == DRAIN);
  end

  // Right column of the window is still one pixel behind; take the newest column from the
  // incoming pixel and the line-buffer taps so the code is ready for the registered write.
  always_comb begin
    w_code         = '0;
    w_code[NB_TL]  = r_win[0][1] >= r_win[1][2];
    w_code[NB_T]   = r_win[0][2] >= r_win[1][2];
    w_code[NB_TR]  = w_lb2       >= r_win[1][2];
    w_code[NB_L]   = r_win[1][1] >= r_win[1][2];
    w_code[NB_R]   = w_lb1       >= r_win[1][2];
    w_code[NB_BL]  = r_win[2][1] >= r_win[1][2];
    w_code[NB_B]   = r_win[2][2] >= r_win[1][2];
    w_code[NB_BR]  = bus.gray_data >= r_win[1][2];
    w_border = (r_cx == '0) || (r_cx == CX_W'(IMG_W - 1)) ||
               (r_cy == '0) || (r_cy == CY_W'(IMG_H - 1));
`ifdef LBP_UNIFORM_EN
    w_out = w_border ? 8'd0 : uniform_label(w_code);
`else
    w_out = w_border ? 8'd0 : w_code;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gaddr  <= '0;
      r_req    <= 1'b0;
      r_caddr  <= '0;
      r_laddr  <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_finish <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      if (r_state == IDLE && bus.gray_ready) r_req <= 1'b1;
      if (w_accept) begin
        r_gaddr <= r_gaddr + 1'b1;
        if (r_gaddr == LAST) r_req <= 1'b0;
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb2;
        r_win[1][2] <= w_lb1;
        r_win[2][2] <= bus.gray_data;
      end
      r_valid <= w_emit;
      if (w_emit) begin
        r_laddr <= r_caddr;
        r_data  <= w_out;
        r_caddr <= r_caddr + 1'b1;
        if (r_cx == CX_W'(IMG_W - 1)) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
      if (r_state == DONE) r_finish <= 1'b1;
    end
  end

  assign bus.gray_addr = r_gaddr;
  assign bus.gray_req  = r_req;
  assign bus.lbp_addr  = r_laddr;
  assign bus.lbp_valid = r_valid;
  assign bus.lbp_data  = r_data;
  assign bus.finish    = r_finish;
endmodule
